pwm_fade_multi: RTL and testbench

- Multi-channel breathing-LED PWM generator; next generation of the single-channel fade PWM driving the board LED bank.
- One shared fade engine sweeps a duty value between programmable floor and ceiling in triangle, sawtooth or hold mode.
- N_CH registered PWM outputs compare against a period-aligned shadow copy of that duty value, so every pulse is glitch-free.
- Optional per-channel phase stagger spreads edges to cut supply current peaks.

---
 rtl/pwm_fade_pkg.sv | 27 ++
 rtl/pwm_fade_engine.sv | 98 +++++++++
 rtl/pwm_fade_multi.sv | 120 ++++++++++++
 tb/tb_pwm_fade_multi.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_fade_pkg.sv
// pwm_fade_pkg
//   Shared definitions for the multi-channel fade PWM: mode encoding,
//   fade direction type and helpers that derive the frame period and the
//   fade ceiling from the top-level parameters.
package pwm_fade_pkg;

   localparam logic [1:0] MODE_OFF  = 2'b00;
   localparam logic [1:0] MODE_TRI  = 2'b01;
   localparam logic [1:0] MODE_SAW  = 2'b10;
   localparam logic [1:0] MODE_HOLD = 2'b11;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   // Clocks per PWM frame.
   function automatic int calc_period(input int clk_freq, input int pwm_freq);
      return clk_freq / pwm_freq;
   endfunction

   // Fade ceiling in counts, truncated.
   function automatic int calc_dmax(input int period, input int pct);
      return (period * pct) / 100;
   endfunction

endpackage

// File: rtl/pwm_fade_engine.sv
// pwm_fade_engine
//   Shared fade engine: a step divider plus the duty/direction state that
//   sweeps duty between DUTY_MIN and DMAX once per step.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   DIR_UP   | triangle ramping up (also the reset/off state)
//   DIR_DOWN | triangle ramping down
//
// Ports:
//   clk     in   clock
//   rst_n   in   asynchronous active-low reset
//   en_i    in   run enable; all state holds while low
//   mode_i  in   fade mode (off / triangle / sawtooth / hold)
//   duty_o  out  current duty value in counts
module pwm_fade_engine
   import pwm_fade_pkg::*;
#(
   parameter int CNT_W    = 16,
   parameter int STEP_DIV = 1,
   parameter int DUTY_MIN = 1,
   parameter int DMAX     = 14000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic [1:0]       mode_i,
   output logic [CNT_W-1:0] duty_o
);

   localparam int SC_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [SC_W-1:0]  SC_LAST = SC_W'(STEP_DIV - 1);
   localparam logic [CNT_W-1:0] DMAX_C  = CNT_W'(DMAX);
   localparam logic [CNT_W-1:0] DMIN_C  = CNT_W'(DUTY_MIN);

   logic [SC_W-1:0]  step_cnt_q, step_cnt_d;
   logic [CNT_W-1:0] duty_q, duty_d;
   dir_e             dir_q, dir_d;
   logic             step;

   assign step = (step_cnt_q == SC_LAST) && en_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_cnt_q <= '0;
         duty_q     <= DMIN_C;
         dir_q      <= DIR_UP;
      end else begin
         step_cnt_q <= step_cnt_d;
         duty_q     <= duty_d;
         dir_q      <= dir_d;
      end
   end

   always_comb begin
      step_cnt_d = step_cnt_q;
      duty_d     = duty_q;
      dir_d      = dir_q;
      if (en_i) begin
         step_cnt_d = step ? '0 : step_cnt_q + 1'b1;
      end
      if (step) begin
         case (mode_i)
            MODE_TRI: begin
               // Direction turns in the same step as the reversal move,
               // so the peak and floor each last exactly one step.
               if (dir_q == DIR_UP) begin
                  if (duty_q < DMAX_C) begin
                     duty_d = duty_q + 1'b1;
                  end else begin
                     dir_d  = DIR_DOWN;
                     duty_d = duty_q - 1'b1;
                  end
               end else begin
                  if (duty_q > DMIN_C) begin
                     duty_d = duty_q - 1'b1;
                  end else begin
                     dir_d  = DIR_UP;
                     duty_d = duty_q + 1'b1;
                  end
               end
            end
            // dir kept so a later return to triangle resumes its direction.
            MODE_SAW:  duty_d = (duty_q < DMAX_C) ? duty_q + 1'b1 : DMIN_C;
            MODE_HOLD: ;
            default: begin
               duty_d = DMIN_C;
               dir_d  = DIR_UP;
            end
         endcase
      end
   end

   always_comb begin
      duty_o = duty_q;
   end

endmodule

// File: rtl/pwm_fade_multi.sv
// pwm_fade_multi
//   Multi-channel breathing-LED PWM. One fade engine drives N_CH registered
//   outputs that compare a per-channel phase against a shadow copy of the
//   duty, reloaded only at the frame wrap so pulses never glitch.
//
//   Build option: define PWM_PHASE_STAGGER_EN to offset channel k by
//   k*(PERIOD/N_CH) counts; otherwise all channels are edge-aligned.
//
// Ports:
//   clk         in   clock
//   rst_n       in   asynchronous active-low reset
//   en          in   global run enable
//   mode        in   00 off, 01 triangle, 10 sawtooth, 11 hold
//   ch_en       in   per-channel output enable
//   pwm_out     out  registered PWM outputs
//   frame_tick  out  one-cycle pulse after the last cycle of each frame
module pwm_fade_multi
   import pwm_fade_pkg::*;
#(
   parameter int CLK_FREQ     = 25_000_000,
   parameter int PWM_FREQ     = 1_250,
   parameter int N_CH         = 8,
   parameter int CNT_W        = 16,
   parameter int STEP_DIV     = 1,
   parameter int DUTY_MAX_PCT = 70,
   parameter int DUTY_MIN     = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic [1:0]      mode,
   input  logic [N_CH-1:0] ch_en,
   output logic [N_CH-1:0] pwm_out,
   output logic            frame_tick
);

   localparam int PERIOD = calc_period(CLK_FREQ, PWM_FREQ);
   localparam int DMAX   = calc_dmax(PERIOD, DUTY_MAX_PCT);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

   if (longint'(PERIOD) > (longint'(1) << CNT_W)) begin : g_err_period
      $error("pwm_fade_multi: PERIOD %0d does not fit in CNT_W=%0d", PERIOD, CNT_W);
   end
   if (DUTY_MIN < 0 || DUTY_MIN >= DMAX) begin : g_err_duty
      $error("pwm_fade_multi: DUTY_MIN %0d must be in [0, DMAX=%0d)", DUTY_MIN, DMAX);
   end
   if (STEP_DIV < 1) begin : g_err_step
      $error("pwm_fade_multi: STEP_DIV %0d must be >= 1", STEP_DIV);
   end
   if (N_CH < 1 || N_CH > 32) begin : g_err_nch
      $error("pwm_fade_multi: N_CH %0d must be in 1..32", N_CH);
   end

   logic [CNT_W-1:0] counter_q, counter_d;
   logic [CNT_W-1:0] duty_sh_q, duty_sh_d;
   logic [CNT_W-1:0] duty;
   logic             frame_tick_q;
   logic [N_CH-1:0]  pwm_q, pwm_d;
   logic             wrap;
   logic             run;

   pwm_fade_engine #(
      .CNT_W    (CNT_W),
      .STEP_DIV (STEP_DIV),
      .DUTY_MIN (DUTY_MIN),
      .DMAX     (DMAX)
   ) u_engine (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (en),
      .mode_i (mode),
      .duty_o (duty)
   );

   assign wrap = en && (counter_q == LAST);
   assign run  = en && (mode != MODE_OFF);

   always_comb begin
      counter_d = counter_q;
      if (en) begin
         counter_d = wrap ? '0 : counter_q + 1'b1;
      end
   end

   // Shadow takes the engine output from before this cycle's step update.
   assign duty_sh_d = wrap ? duty : duty_sh_q;

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      logic [CNT_W-1:0] phase;
`ifdef PWM_PHASE_STAGGER_EN
      localparam int OFS = k * (PERIOD / N_CH);
      logic [CNT_W:0] sum;
      // counter + OFS < 2*PERIOD, so one conditional subtract is a full mod.
      assign sum   = {1'b0, counter_q} + (CNT_W+1)'(OFS);
      assign phase = (sum >= (CNT_W+1)'(PERIOD)) ? CNT_W'(sum - (CNT_W+1)'(PERIOD))
                                                 : sum[CNT_W-1:0];
`else
      assign phase = counter_q;
`endif
      assign pwm_d[k] = run && ch_en[k] && (phase < duty_sh_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         counter_q    <= '0;
         duty_sh_q    <= '0;
         frame_tick_q <= 1'b0;
         pwm_q        <= '0;
      end else begin
         counter_q    <= counter_d;
         duty_sh_q    <= duty_sh_d;
         frame_tick_q <= wrap;
         pwm_q        <= pwm_d;
      end
   end

   assign pwm_out    = pwm_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_pwm_fade_multi.sv
// tb_pwm_fade_multi
//   Frame-level scoreboard for pwm_fade_multi with PERIOD=10, N_CH=2,
//   STEP_DIV=10, DMAX=7, DUTY_MIN=1. Each expected frame (duty, ch_en) is
//   queued; on frame_tick the recorded per-position high mask of each
//   channel is compared against the mask that duty implies.
module tb_pwm_fade_multi;

   localparam logic [1:0] M_OFF  = 2'b00;
   localparam logic [1:0] M_TRI  = 2'b01;
   localparam logic [1:0] M_SAW  = 2'b10;
   localparam logic [1:0] M_HOLD = 2'b11;
   localparam int         PER    = 10;
`ifdef PWM_PHASE_STAGGER_EN
   localparam int         OFS    = 5;
`else
   localparam int         OFS    = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [1:0] mode = M_OFF;
   logic [1:0] ch_en = 2'b00;
   logic [1:0] pwm_out;
   logic       frame_tick;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int         d;
      logic [1:0] chen;
   } exp_t;
   exp_t exp_q[$];

   int         en_cnt = 0;
   int         fidx = 0;
   logic [9:0] m0 = '0;
   logic [9:0] m1 = '0;

   pwm_fade_multi #(
      .CLK_FREQ     (1000),
      .PWM_FREQ     (100),
      .N_CH         (2),
      .CNT_W        (16),
      .STEP_DIV     (10),
      .DUTY_MAX_PCT (70),
      .DUTY_MIN     (1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .mode       (mode),
      .ch_en      (ch_en),
      .pwm_out    (pwm_out),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Positions (counter values) at which channel k is high for duty d.
   function automatic logic [9:0] exp_mask(input int d, input int k, input logic on);
      logic [9:0] m = '0;
      int ph;
      if (on) begin
         for (int c = 0; c < PER; c++) begin
            ph = c + k * OFS;
            if (ph >= PER) ph = ph - PER;
            if (ph < d) m[c] = 1'b1;
         end
      end
      return m;
   endfunction

   task automatic push(input int d, input logic [1:0] chen);
      exp_t e;
      e.d    = d;
      e.chen = chen;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_empty(input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
      chk("queue_drain", exp_q.size(), 0);
   endtask

   task automatic wait_ticks(input int n);
      int seen = 0;
      for (int i = 0; i < n * 30 && seen < n; i++) begin
         @(posedge clk);
         #1;
         if (frame_tick) seen++;
      end
      chk("tick_wait", seen, n);
      @(negedge clk);
   endtask

   // Monitor: one sample per clock, 1 time unit after the active edge.
   // A sample after an enabled edge shows the result for counter en_cnt-1.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            en_cnt = 0;
            m0     = '0;
            m1     = '0;
         end else begin
            if (en) en_cnt++;
            if (en_cnt >= 1 && en_cnt <= PER) begin
               if (pwm_out[0]) m0[en_cnt-1] = 1'b1;
               if (pwm_out[1]) m1[en_cnt-1] = 1'b1;
            end
            if (frame_tick) begin
               chk("frame_len", en_cnt, PER);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  chk($sformatf("f%0d_ch0_d%0d", fidx, e.d), m0, exp_mask(e.d, 0, e.chen[0]));
                  chk($sformatf("f%0d_ch1_d%0d", fidx, e.d), m1, exp_mask(e.d, 1, e.chen[1]));
               end
               fidx++;
               en_cnt = 0;
               m0     = '0;
               m1     = '0;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      int tri_seq[15]  = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 2};
      int saw_seq[10]  = '{0, 1, 2, 3, 4, 5, 6, 7, 1, 2};
      int hold_seq[12] = '{0, 1, 2, 3, 4, 4, 4, 4, 5, 6, 7, 6};
      int waited;
      logic [1:0] gap_pwm;
      logic       gap_tick;

      // Reset state
      mode  = M_TRI;
      ch_en = 2'b11;
      en    = 1'b1;
      rst_n = 1'b0;
      #12;
      chk("rst_pwm", pwm_out, 0);
      chk("rst_tick", frame_tick, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Triangle
      foreach (tri_seq[i]) push(tri_seq[i], 2'b11);
      wait_empty(400);

      // Asynchronous reset while an output is high, then restart from floor
      waited = 0;
      while (pwm_out == 2'b00 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      chk("pre_rst_high", (pwm_out != 2'b00), 1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_pwm", pwm_out, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      push(0, 2'b11);
      push(1, 2'b11);
      push(2, 2'b11);
      wait_empty(200);

      // Sawtooth
      mode = M_SAW;
      do_reset();
      foreach (saw_seq[i]) push(saw_seq[i], 2'b11);
      wait_empty(300);

      // Hold at duty 4, then back to triangle
      mode = M_TRI;
      do_reset();
      foreach (hold_seq[i]) push(hold_seq[i], 2'b11);
      wait_ticks(3);
      mode = M_HOLD;
      wait_ticks(3);
      mode = M_TRI;
      wait_empty(300);

      // Enable gap of 13 clocks in the middle of the duty-4 frame
      do_reset();
      for (int d = 0; d <= 5; d++) push(d, 2'b11);
      wait_ticks(4);
      @(negedge clk);
      en       = 1'b0;
      gap_pwm  = '0;
      gap_tick = 1'b0;
      repeat (13) begin
         @(negedge clk);
         gap_pwm  = gap_pwm | pwm_out;
         gap_tick = gap_tick | frame_tick;
      end
      en = 1'b1;
      chk("gap_pwm_low", gap_pwm, 0);
      chk("gap_tick_low", gap_tick, 0);
      wait_empty(300);

      // Channel 1 disabled
      ch_en = 2'b01;
      do_reset();
      for (int d = 0; d <= 4; d++) push(d, 2'b01);
      wait_empty(200);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
